// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI-flash responder: command opcodes, FSM
// state encoding, data-byte source selector and the JEDEC byte picker.
package spi_flash_pkg;

    localparam int ADDR_W = 24;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_RDSR      = 8'h05;
    localparam logic [7:0] CMD_RDID      = 8'h9F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } spi_rsp_state_t;

    // Where the next outgoing data byte comes from.
    typedef enum logic [1:0] {
        SRC_MEM,
        SRC_STATUS,
        SRC_JEDEC
    } byte_src_t;

    // JEDEC ID bytes MSB first; anything past the third byte reads as 00h.
    function automatic logic [7:0] jedec_byte(input logic [23:0] id,
                                              input logic [1:0]  idx);
        case (idx)
            2'd0:    jedec_byte = id[23:16];
            2'd1:    jedec_byte = id[15:8];
            2'd2:    jedec_byte = id[7:0];
            default: jedec_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// spi_in_sync: two-flop synchronizers for the asynchronous SPI pins plus
// ck edge detection.
//   clk, reset      : system clock, synchronous active-high reset
//   ck, cs, si      : raw SPI pins
//   cs_s, si_s      : synchronized chip select / data in
//   ck_rise, ck_fall: one-cycle strobes, registered, 3 clk after the pin edge
module spi_in_sync (
    input  logic clk,
    input  logic reset,
    input  logic ck,
    input  logic cs,
    input  logic si,
    output logic cs_s,
    output logic si_s,
    output logic ck_rise,
    output logic ck_fall
);

    // bit order {ck, cs, si}; idle pin levels are ck low, cs high
    logic [2:0] meta;
    logic [2:0] sync;
    logic       ck_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta    <= 3'b010;
            sync    <= 3'b010;
            ck_d    <= 1'b0;
            ck_rise <= 1'b0;
            ck_fall <= 1'b0;
        end else begin
            meta    <= {ck, cs, si};
            sync    <= meta;
            ck_d    <= sync[2];
            ck_rise <= sync[2] & ~ck_d;
            ck_fall <= ~sync[2] & ck_d;
        end
    end

    assign cs_s = sync[1];
    assign si_s = sync[0];

endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 flash target running entirely on clk.
// Decodes READ (03h), FAST READ (0Bh), READ STATUS (05h) and JEDEC ID (9Fh);
// read data is prefetched one byte ahead from a byte-wide memory port.
//   clk, reset                    : system clock, synchronous active-high reset
//   flash_ck/flash_cs/flash_si    : SPI pins from the master (asynchronous)
//   flash_so                      : SPI data out, 1 when not shifting data
//   mem_addr/mem_req              : read request, held until mem_ack
//   mem_data/mem_ack              : read data with one-cycle strobe
//   underrun                      : sticky, a data byte was due before its data
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter logic [23:0] JEDEC_ID = 24'hEF4016,
    parameter logic [7:0]  STATUS   = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flash_ck,
    input  logic              flash_cs,
    input  logic              flash_si,
    output logic              flash_so,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic [7:0]        mem_data,
    input  logic              mem_ack,
    output logic              underrun
);

    logic cs_s, si_s, ck_rise, ck_fall, cs_q;
    logic cs_rise, cs_fall;

    spi_in_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .ck      (flash_ck),
        .cs      (flash_cs),
        .si      (flash_si),
        .cs_s    (cs_s),
        .si_s    (si_s),
        .ck_rise (ck_rise),
        .ck_fall (ck_fall)
    );

    assign cs_rise = cs_s & ~cs_q;
    assign cs_fall = ~cs_s & cs_q;

    spi_rsp_state_t    state, state_n;
    logic [4:0]        bit_cnt;
    logic [6:0]        in_sr;      // command bits received so far
    logic [ADDR_W-2:0] addr_sr;    // address bits received so far
    logic              fast;
    byte_src_t         src;
    logic [1:0]        jedec_idx;
    logic [6:0]        out_sr;     // bits still to be shifted out
    logic              buf_valid;
    logic [7:0]        buf_data;
    logic              discard;    // outstanding request belongs to a dead transaction
    logic              want;       // request waiting for the dead one to be acked
    logic [ADDR_W-1:0] want_addr;

    logic [7:0]        cmd_byte;
    logic [ADDR_W-1:0] addr_word;
    logic [7:0]        ld_byte;
    logic              cnt_evt, cmd_done, addr_done, data_fall;

    assign cmd_byte  = {in_sr, si_s};
    assign addr_word = {addr_sr, si_s};

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // CS rise outranks any ck edge seen in the same cycle.
    always_comb begin
        state_n = state;
        if (state == ST_IDLE) begin
            if (cs_fall) state_n = ST_CMD;
        end else if (cs_rise) begin
            state_n = ST_IDLE;
        end else if (ck_rise) begin
            case (state)
                ST_CMD: if (bit_cnt == 5'd7) begin
                    case (cmd_byte)
                        CMD_READ, CMD_FAST_READ: state_n = ST_ADDR;
                        CMD_RDSR, CMD_RDID:      state_n = ST_DATA;
                        default:                 state_n = ST_IGNORE;
                    endcase
                end
                ST_ADDR:  if (bit_cnt == 5'd23) state_n = fast ? ST_DUMMY : ST_DATA;
                ST_DUMMY: if (bit_cnt == 5'd7)  state_n = ST_DATA;
                default: ;
            endcase
        end
    end

    always_comb begin
        ld_byte = 8'hFF;
        case (src)
            SRC_MEM:    if (buf_valid) ld_byte = buf_data;
            SRC_STATUS: ld_byte = STATUS;
            SRC_JEDEC:  ld_byte = jedec_byte(JEDEC_ID, jedec_idx);
            default: ;
        endcase
    end

    assign cnt_evt   = (ck_rise && (state == ST_CMD || state == ST_ADDR || state == ST_DUMMY))
                    || (ck_fall && state == ST_DATA);
    assign cmd_done  = state == ST_CMD  && ck_rise && bit_cnt == 5'd7  && !cs_rise;
    assign addr_done = state == ST_ADDR && ck_rise && bit_cnt == 5'd23 && !cs_rise;
    assign data_fall = state == ST_DATA && ck_fall && !cs_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q      <= 1'b1;
            bit_cnt   <= '0;
            in_sr     <= '0;
            addr_sr   <= '0;
            fast      <= 1'b0;
            src       <= SRC_MEM;
            jedec_idx <= '0;
            out_sr    <= '1;
            flash_so  <= 1'b1;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            buf_valid <= 1'b0;
            buf_data  <= '0;
            discard   <= 1'b0;
            want      <= 1'b0;
            want_addr <= '0;
            underrun  <= 1'b0;
        end else begin
            cs_q <= cs_s;

            // Memory handshake; later statements may override these.
            if (mem_req && mem_ack) begin
                mem_req <= 1'b0;
                if (discard) begin
                    discard <= 1'b0;
                end else begin
                    buf_data  <= mem_data;
                    buf_valid <= 1'b1;
                end
            end else if (want && !mem_req) begin
                mem_req  <= 1'b1;
                mem_addr <= want_addr;
                want     <= 1'b0;
            end

            if (state_n != state) bit_cnt <= '0;
            else if (cnt_evt)     bit_cnt <= bit_cnt + 5'd1;

            if (ck_rise) begin
                in_sr   <= {in_sr[5:0], si_s};
                addr_sr <= {addr_sr[ADDR_W-3:0], si_s};
            end

            if (state == ST_IDLE && cs_fall) underrun <= 1'b0;

            if (cmd_done) begin
                fast      <= (cmd_byte == CMD_FAST_READ);
                jedec_idx <= '0;
                if (cmd_byte == CMD_RDSR)      src <= SRC_STATUS;
                else if (cmd_byte == CMD_RDID) src <= SRC_JEDEC;
                else                           src <= SRC_MEM;
            end

            // An abandoned request may still be in flight; queue behind it.
            if (addr_done) begin
                if (mem_req) begin
                    want      <= 1'b1;
                    want_addr <= addr_word;
                end else begin
                    mem_req  <= 1'b1;
                    mem_addr <= addr_word;
                end
            end

            if (state != ST_DATA) begin
                flash_so <= 1'b1;
            end else if (data_fall) begin
                if (bit_cnt[2:0] == 3'd0) begin
                    out_sr   <= ld_byte[6:0];
                    flash_so <= ld_byte[7];
                    if (src == SRC_MEM) begin
                        if (buf_valid) begin
                            buf_valid <= 1'b0;
                            mem_addr  <= mem_addr + 24'd1;
                            mem_req   <= 1'b1;
                        end else begin
                            // keep the outstanding request; its data feeds the next byte
                            underrun <= 1'b1;
                        end
                    end
                    if (src == SRC_JEDEC && jedec_idx != 2'd3)
                        jedec_idx <= jedec_idx + 2'd1;
                end else begin
                    out_sr   <= {out_sr[5:0], 1'b1};
                    flash_so <= out_sr[6];
                end
            end

            if (cs_rise && state != ST_IDLE) begin
                flash_so  <= 1'b1;
                buf_valid <= 1'b0;
                want      <= 1'b0;
                discard   <= mem_req && !mem_ack;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flash_ck = 1'b0;
    logic        flash_cs = 1'b1;
    logic        flash_si = 1'b0;
    logic        flash_so;
    logic [23:0] mem_addr;
    logic        mem_req;
    logic [7:0]  mem_data = 8'h00;
    logic        mem_ack = 1'b0;
    logic        underrun;

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;
    int lat_cnt = 0;
    bit hash_mode = 1'b0;

    always #5 clk = ~clk;

    spi_flash_responder dut (
        .clk      (clk),
        .reset    (reset),
        .flash_ck (flash_ck),
        .flash_cs (flash_cs),
        .flash_si (flash_si),
        .flash_so (flash_so),
        .mem_addr (mem_addr),
        .mem_req  (mem_req),
        .mem_data (mem_data),
        .mem_ack  (mem_ack),
        .underrun (underrun)
    );

    // Memory contents as a pure function of the address.
    function automatic logic [7:0] mem_fn(input logic [23:0] a, input bit h);
        return h ? (a[7:0] ^ a[23:16] ^ 8'h5A) : a[7:0];
    endfunction

    // Memory model: ack mem_lat clocks after it first sees mem_req high.
    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (reset || !mem_req) begin
            lat_cnt = 0;
        end else begin
            lat_cnt++;
            if (lat_cnt >= mem_lat) begin
                mem_ack  = 1'b1;
                mem_data = mem_fn(mem_addr, hash_mode);
                lat_cnt  = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 0 master at clk/10: data set while ck low, sampled on ck rise.
    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            flash_si = tx[i];
            tick(5);
            flash_ck = 1'b1;
            rx[i]    = flash_so;
            tick(5);
            flash_ck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_low();
        flash_cs = 1'b0;
        tick(5);
    endtask

    task automatic cs_high();
        tick(5);
        flash_cs = 1'b1;
        tick(10);
    endtask

    task automatic send_cmd_addr(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] rx;
        spi_byte(cmd, rx);
        spi_byte(a[23:16], rx);
        spi_byte(a[15:8], rx);
        spi_byte(a[7:0], rx);
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if (flash_so !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 24'h0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: so=%b req=%b addr=%h urun=%b, want 1 0 000000 0",
                     flash_so, mem_req, mem_addr, underrun);
        end
        reset = 1'b0;
        tick(3);
        checks++;
        if (flash_so !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 24'h0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: so=%b req=%b addr=%h urun=%b, want 1 0 000000 0",
                     flash_so, mem_req, mem_addr, underrun);
        end
    endtask

    // 03h read of n bytes with the bench's memory model as reference.
    task automatic do_read(input string name, input logic [23:0] a, input int n);
        logic [7:0] rx;
        logic [7:0] exp;
        cs_low();
        send_cmd_addr(8'h03, a);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, rx);
            exp = mem_fn(a + 24'(i), hash_mode);
            checks++;
            if (rx !== exp) begin
                errors++;
                $display("FAIL %s byte%0d: got %h want %h", name, i, rx, exp);
            end
        end
        cs_high();
        // one load per byte plus the load on the closing ck fall
        checks++;
        if (mem_addr !== a + 24'(n + 1)) begin
            errors++;
            $display("FAIL %s end_addr: got %h want %h", name, mem_addr, a + 24'(n + 1));
        end
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL %s underrun: got %b want 0", name, underrun);
        end
    endtask

    task automatic test_read();
        hash_mode = 1'b0;
        mem_lat   = 1;
        do_read("read_3fe512", 24'h3FE512, 16);
    endtask

    task automatic test_rdid();
        logic [7:0] rx;
        logic [7:0] exp [5] = '{8'hEF, 8'h40, 8'h16, 8'h00, 8'h00};
        cs_low();
        spi_byte(8'h9F, rx);
        for (int i = 0; i < 5; i++) begin
            spi_byte(8'h00, rx);
            checks++;
            if (rx !== exp[i]) begin
                errors++;
                $display("FAIL rdid byte%0d: got %h want %h", i, rx, exp[i]);
            end
        end
        cs_high();
    endtask

    task automatic test_rdsr();
        logic [7:0] rx;
        cs_low();
        spi_byte(8'h05, rx);
        for (int i = 0; i < 2; i++) begin
            spi_byte(8'hFF, rx);
            checks++;
            if (rx !== 8'h00) begin
                errors++;
                $display("FAIL rdsr byte%0d: got %h want 00", i, rx);
            end
        end
        cs_high();
    endtask

    task automatic test_fast_read();
        logic [7:0]  rx;
        logic [7:0]  exp;
        logic [23:0] a;
        hash_mode = 1'b1;
        mem_lat   = 3;
        a = 24'hFFFFFE;
        cs_low();
        send_cmd_addr(8'h0B, a);
        spi_byte(8'($urandom), rx);
        for (int i = 0; i < 4; i++) begin
            spi_byte(8'h00, rx);
            exp = mem_fn(a + 24'(i), 1'b1);
            checks++;
            if (rx !== exp) begin
                errors++;
                $display("FAIL fast_read byte%0d: got %h want %h", i, rx, exp);
            end
        end
        cs_high();
        checks++;
        if (mem_addr !== 24'h000003) begin
            errors++;
            $display("FAIL fast_read wrap_addr: got %h want 000003", mem_addr);
        end
    endtask

    task automatic test_cs_abort();
        logic [7:0] rx;
        hash_mode = 1'b0;
        mem_lat   = 3;
        cs_low();
        send_cmd_addr(8'h03, 24'h000040);
        spi_byte(8'h00, rx);
        checks++;
        if (rx !== 8'h40) begin
            errors++;
            $display("FAIL abort first_byte: got %h want 40", rx);
        end
        // slow memory so a request is still in flight when CS rises
        mem_lat = 40;
        spi_bits(8'h00, 3, rx);
        checks++;
        if (rx[7:5] !== 3'b010 || flash_so !== 1'b0) begin
            errors++;
            $display("FAIL abort partial: bits=%b so=%b want 010 0", rx[7:5], flash_so);
        end
        tick(5);
        flash_cs = 1'b1;
        tick(4);
        checks++;
        if (flash_so !== 1'b1) begin
            errors++;
            $display("FAIL abort so_high: got %b want 1", flash_so);
        end
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL abort req_held: got %b want 1", mem_req);
        end
        tick(10);
        mem_lat = 2;
        tick(10);
        do_read("after_abort", 24'h000010, 2);
    endtask

    task automatic test_underrun();
        logic [7:0]  rx;
        logic [7:0]  exp [3];
        logic [23:0] a;
        hash_mode = 1'b1;
        mem_lat   = 20;
        a = 24'($urandom);
        exp[0] = 8'hFF;
        exp[1] = mem_fn(a, 1'b1);
        exp[2] = mem_fn(a + 24'd1, 1'b1);
        cs_low();
        send_cmd_addr(8'h03, a);
        for (int i = 0; i < 3; i++) begin
            spi_byte(8'h00, rx);
            checks++;
            if (rx !== exp[i]) begin
                errors++;
                $display("FAIL underrun byte%0d: got %h want %h", i, rx, exp[i]);
            end
        end
        cs_high();
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun flag: got %b want 1", underrun);
        end
        checks++;
        if (mem_addr !== a + 24'd3) begin
            errors++;
            $display("FAIL underrun end_addr: got %h want %h", mem_addr, a + 24'd3);
        end
    endtask

    task automatic test_ignore();
        logic [7:0] rx;
        int bad = 0;
        mem_lat = 1;
        cs_low();
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL ignore underrun_clear: got %b want 0", underrun);
        end
        spi_byte(8'h9A, rx);
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (flash_so !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ignore so_held: %0d of 16 clocks low, want 0", bad);
        end
        spi_byte(8'h00, rx);
        checks++;
        if (rx !== 8'hFF) begin
            errors++;
            $display("FAIL ignore byte: got %h want FF", rx);
        end
        cs_high();
    endtask

    task automatic test_random_reads();
        hash_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_lat = $urandom_range(1, 3);
            do_read("rand_read", 24'($urandom), $urandom_range(1, 6));
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0]  rx;
        logic [23:0] a;
        hash_mode = 1'b1;
        mem_lat   = 1;
        a = 24'($urandom);
        cs_low();
        send_cmd_addr(8'h03, a);
        spi_byte(8'h00, rx);
        mem_lat = 50;
        spi_byte(8'h00, rx);
        spi_bits(8'h00, 4, rx);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid pre_req: got %b want 1", mem_req);
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if (flash_so !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 24'h0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid outputs: so=%b req=%b addr=%h urun=%b, want 1 0 000000 0",
                     flash_so, mem_req, mem_addr, underrun);
        end
        flash_cs = 1'b1;
        flash_ck = 1'b0;
        tick(2);
        reset   = 1'b0;
        mem_lat = 1;
        tick(10);
        do_read("after_reset", 24'h000020, 1);
    endtask

    initial begin
        test_reset();
        test_read();
        test_rdid();
        test_rdsr();
        test_fast_read();
        test_cs_abort();
        test_underrun();
        test_ignore();
        test_random_reads();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
